// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply controller: state encoding,
// counter width and default timing parameters.
package hilo_pkg;

    localparam int MIN_LAT_DEF = 33;
    localparam int TIMEOUT_DEF = 64;
    localparam int CNT_W       = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WB   = 2'd2
    } hilo_state_t;

endpackage

// File: rtl/hilo_ctrl.sv
// HI/LO register file plus sequencer for an external multi-cycle multiplier.
// Launches the multiplier, waits out its minimum latency, writes back or times out.
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int MIN_LAT = MIN_LAT_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_start,
    input  logic [31:0]       op_a,
    input  logic [31:0]       op_b,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [31:0]       wdata,
    output logic [31:0]       mul_a,
    output logic [31:0]       mul_b,
    output logic              mul_init,
    input  logic              mul_done,
    input  logic [31:0]       mul_hi,
    input  logic [31:0]       mul_lo,
    output logic [31:0]       hi,
    output logic [31:0]       lo,
    output logic              busy,
    output logic              done_pulse,
    output logic              err,
    output hilo_state_t       dbg_state,
    output logic [CNT_W-1:0]  dbg_cnt
);

    localparam logic [CNT_W-1:0] MIN_LAT_C = CNT_W'(MIN_LAT);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    hilo_state_t       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [31:0]       mul_a_q;
    logic [31:0]       mul_b_q;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;
    logic              mul_init_q;
    logic              busy_q;
    logic              done_pulse_q;
    logic              err_q;

    // Saturating increment so a stuck RUN never wraps back under MIN_LAT.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            mul_init_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_pulse_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_pulse_q <= 1'b0;
            if (mthi) begin
                hi_q <= wdata;
            end
            if (mtlo) begin
                lo_q <= wdata;
            end
            case (state_q)
                ST_IDLE: begin
                    if (op_start) begin
                        mul_a_q    <= op_a;
                        mul_b_q    <= op_b;
                        err_q      <= 1'b0;
                        cnt_q      <= '0;
                        mul_init_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_d;
                    // A done level seen before MIN_LAT may be stale from the last operation.
                    if (mul_done && (cnt_q >= MIN_LAT_C)) begin
                        mul_init_q   <= 1'b0;
                        done_pulse_q <= 1'b1;
                        state_q      <= ST_WB;
                    end else if (cnt_d == TIMEOUT_C) begin
                        mul_init_q <= 1'b0;
                        busy_q     <= 1'b0;
                        err_q      <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_WB: begin
                    // Placed after the mthi/mtlo writes so the product wins a collision.
                    hi_q    <= mul_hi;
                    lo_q    <= mul_lo;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    mul_init_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign mul_init   = mul_init_q;
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign busy       = busy_q;
    assign done_pulse = done_pulse_q;
    assign err        = err_q;
    assign dbg_state  = state_q;
    assign dbg_cnt    = cnt_q;

endmodule
